vcve2_dmem_responder: RTL and testbench

// Memory-side end of the core data-memory req/gnt/rvalid protocol; sits behind the dmem arbiter's data_* port.

---
 rtl/vcve2_dmem_pkg.sv | 18 +
 rtl/vcve2_dmem_if.sv | 25 ++
 rtl/vcve2_dmem_resp_pipe.sv | 64 ++++++
 rtl/vcve2_dmem_responder.sv | 105 ++++++++++
 tb/tb_vcve2_dmem_responder.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vcve2_dmem_pkg.sv
// Shared types for the data-memory responder.
// Response metadata and grant FSM states.
package vcve2_dmem_pkg;

   localparam int unsigned CntWidth = 4;

   typedef struct packed {
      logic valid;
      logic we;
      logic err;
   } dmem_resp_meta_t;

   typedef enum logic {
      IDLE,
      WAIT
   } dmem_gnt_state_e;

endpackage

// File: rtl/vcve2_dmem_if.sv
// Core data-memory req/gnt/rvalid bus.
// master = initiator (LSU/arbiter), slave = memory responder.
interface vcve2_dmem_if;

   logic        req;
   logic        gnt;
   logic        rvalid;
   logic        we;
   logic [3:0]  be;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        err;

   modport master (
      output req, we, be, addr, wdata,
      input  gnt, rvalid, rdata, err
   );

   modport slave (
      input  req, we, be, addr, wdata,
      output gnt, rvalid, rdata, err
   );

endinterface

// File: rtl/vcve2_dmem_resp_pipe.sv
// Fixed-latency response delay line carrying {valid, we, err}.
// SRAM read data joins the entry one cycle after the grant.
module vcve2_dmem_resp_pipe
   import vcve2_dmem_pkg::*;
#(
   parameter int unsigned RespLatency = 1
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  dmem_resp_meta_t meta_i,
   input  logic [31:0]     sram_rdata_i,
   output dmem_resp_meta_t meta_o,
   output logic [31:0]     rdata_o
);

   dmem_resp_meta_t meta_q [RespLatency];
   dmem_resp_meta_t meta_d [RespLatency];
   logic [31:0]     data_w;

   always_comb begin
      meta_d[0] = meta_i;
      for (int i = 1; i < RespLatency; i++) begin
         meta_d[i] = meta_q[i-1];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= '{default: '0};
      end else begin
         meta_q <= meta_d;
      end
   end

   // With one stage the SRAM output is already aligned with rvalid.
   if (RespLatency == 1) begin : g_direct
      assign data_w = sram_rdata_i;
   end else begin : g_delay
      logic [31:0] data_q [1:RespLatency-1];
      logic [31:0] data_d [1:RespLatency-1];

      always_comb begin
         data_d[1] = sram_rdata_i;
         for (int i = 2; i < RespLatency; i++) begin
            data_d[i] = data_q[i-1];
         end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            data_q <= '{default: '0};
         end else begin
            data_q <= data_d;
         end
      end

      assign data_w = data_q[RespLatency-1];
   end

   assign meta_o  = meta_q[RespLatency-1];
   assign rdata_o = (meta_o.valid && !meta_o.we && !meta_o.err) ?
                    data_w : 32'h0;

endmodule

// File: rtl/vcve2_dmem_responder.sv
// Memory-side responder for the core data bus: grants requests,
// drives a 1-cycle SRAM, returns one in-order rvalid per grant.
module vcve2_dmem_responder
   import vcve2_dmem_pkg::*;
#(
   parameter logic [31:0] BaseAddr    = 32'h0000_0000,
   parameter int unsigned MemBytes    = 65536,
   parameter int unsigned GntDelay    = 0,
   parameter int unsigned RespLatency = 1,
   localparam int unsigned AddrWidth  = $clog2(MemBytes / 4)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   vcve2_dmem_if.slave          data,
   output logic                 sram_req_o,
   output logic                 sram_we_o,
   output logic [3:0]           sram_be_o,
   output logic [AddrWidth-1:0] sram_addr_o,
   output logic [31:0]          sram_wdata_o,
   input  logic [31:0]          sram_rdata_i
);

   dmem_gnt_state_e     state_q, state_d;
   logic [CntWidth-1:0] cnt_q, cnt_d;
   logic                gnt;
   logic                err;
   logic [31:0]         offset;
   dmem_resp_meta_t     meta_in, meta_out;
   logic [31:0]         rdata;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gnt     = 1'b0;
      if (GntDelay == 0) begin
         gnt = data.req;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (data.req) begin
                  state_d = WAIT;
                  cnt_d   = CntWidth'(1);
               end
            end
            WAIT: begin
               // A dropped request is legal: the arbiter may switch source.
               if (!data.req) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else if (cnt_q == CntWidth'(GntDelay)) begin
                  gnt     = 1'b1;
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CntWidth'(1);
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Unsigned subtraction makes addresses below the base wrap out of range.
   assign offset = data.addr - BaseAddr;
   assign err    = (offset >= MemBytes) || (data.addr[1:0] != 2'b00);

   assign sram_req_o   = gnt && !err;
   assign sram_we_o    = data.we;
   assign sram_be_o    = data.be;
   assign sram_addr_o  = offset[AddrWidth+1:2];
   assign sram_wdata_o = data.wdata;

   always_comb begin
      meta_in       = '0;
      meta_in.valid = gnt;
      meta_in.we    = gnt && data.we;
      meta_in.err   = gnt && err;
   end

   vcve2_dmem_resp_pipe #(
      .RespLatency (RespLatency)
   ) u_resp_pipe (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .meta_i       (meta_in),
      .sram_rdata_i (sram_rdata_i),
      .meta_o       (meta_out),
      .rdata_o      (rdata)
   );

   assign data.gnt    = gnt;
   assign data.rvalid = meta_out.valid;
   assign data.err    = meta_out.valid && meta_out.err;
   assign data.rdata  = rdata;

endmodule

// File: tb/tb_vcve2_dmem_responder.sv
// Scoreboard bench for vcve2_dmem_responder: three configurations
// (0/1, 3/1 with offset base, 0/4) driven with directed vectors.
module tb_vcve2_dmem_responder;

   localparam int GD [3]  = '{0, 3, 0};
   localparam int LAT [3] = '{1, 1, 4};

   typedef struct {
      logic        err;
      logic [31:0] rd;
      int          cyc;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   checks;
   int   errors;

   exp_t q0 [$];
   exp_t q1 [$];
   exp_t q2 [$];

   logic        req [3];
   logic        we [3];
   logic [3:0]  be [3];
   logic [31:0] addr [3];
   logic [31:0] wdata [3];

   logic        gnt [3];
   logic        rv [3];
   logic        eo [3];
   logic [31:0] rd [3];
   logic        sreq [3];
   logic [3:0]  sbe [3];
   logic [31:0] saddr [3];

   vcve2_dmem_if if0 ();
   vcve2_dmem_if if1 ();
   vcve2_dmem_if if2 ();

   logic        s0_req, s1_req, s2_req;
   logic        s0_we, s1_we, s2_we;
   logic [3:0]  s0_be, s1_be, s2_be;
   logic [13:0] s0_addr, s2_addr;
   logic [5:0]  s1_addr;
   logic [31:0] s0_wd, s1_wd, s2_wd;
   logic [31:0] s0_rd, s1_rd, s2_rd;
   logic [31:0] m0 [64];
   logic [31:0] m1 [64];
   logic [31:0] m2 [64];

   assign if0.req = req[0];
   assign if0.we = we[0];
   assign if0.be = be[0];
   assign if0.addr = addr[0];
   assign if0.wdata = wdata[0];
   assign if1.req = req[1];
   assign if1.we = we[1];
   assign if1.be = be[1];
   assign if1.addr = addr[1];
   assign if1.wdata = wdata[1];
   assign if2.req = req[2];
   assign if2.we = we[2];
   assign if2.be = be[2];
   assign if2.addr = addr[2];
   assign if2.wdata = wdata[2];

   assign gnt[0] = if0.gnt;
   assign gnt[1] = if1.gnt;
   assign gnt[2] = if2.gnt;
   assign rv[0] = if0.rvalid;
   assign rv[1] = if1.rvalid;
   assign rv[2] = if2.rvalid;
   assign eo[0] = if0.err;
   assign eo[1] = if1.err;
   assign eo[2] = if2.err;
   assign rd[0] = if0.rdata;
   assign rd[1] = if1.rdata;
   assign rd[2] = if2.rdata;
   assign sreq[0] = s0_req;
   assign sreq[1] = s1_req;
   assign sreq[2] = s2_req;
   assign sbe[0] = s0_be;
   assign sbe[1] = s1_be;
   assign sbe[2] = s2_be;
   assign saddr[0] = 32'(s0_addr);
   assign saddr[1] = 32'(s1_addr);
   assign saddr[2] = 32'(s2_addr);

   vcve2_dmem_responder dut0 (
      .clk_i (clk), .rst_ni (rst_n), .data (if0.slave),
      .sram_req_o (s0_req), .sram_we_o (s0_we), .sram_be_o (s0_be),
      .sram_addr_o (s0_addr), .sram_wdata_o (s0_wd),
      .sram_rdata_i (s0_rd)
   );

   vcve2_dmem_responder #(
      .BaseAddr (32'h0000_1000), .MemBytes (256), .GntDelay (3)
   ) dut1 (
      .clk_i (clk), .rst_ni (rst_n), .data (if1.slave),
      .sram_req_o (s1_req), .sram_we_o (s1_we), .sram_be_o (s1_be),
      .sram_addr_o (s1_addr), .sram_wdata_o (s1_wd),
      .sram_rdata_i (s1_rd)
   );

   vcve2_dmem_responder #(.RespLatency (4)) dut2 (
      .clk_i (clk), .rst_ni (rst_n), .data (if2.slave),
      .sram_req_o (s2_req), .sram_we_o (s2_we), .sram_be_o (s2_be),
      .sram_addr_o (s2_addr), .sram_wdata_o (s2_wd),
      .sram_rdata_i (s2_rd)
   );

   // SRAM models: word i resets to 32'hA500_0000 | i.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 64; i++) begin
            m0[i] <= 32'hA500_0000 | 32'(i);
            m1[i] <= 32'hA500_0000 | 32'(i);
            m2[i] <= 32'hA500_0000 | 32'(i);
         end
         s0_rd <= '0;
         s1_rd <= '0;
         s2_rd <= '0;
      end else begin
         if (s0_req && s0_we) begin
            for (int b = 0; b < 4; b++)
               if (s0_be[b]) m0[s0_addr[5:0]][8*b +: 8] <= s0_wd[8*b +: 8];
         end else if (s0_req) s0_rd <= m0[s0_addr[5:0]];
         if (s1_req && s1_we) begin
            for (int b = 0; b < 4; b++)
               if (s1_be[b]) m1[s1_addr][8*b +: 8] <= s1_wd[8*b +: 8];
         end else if (s1_req) s1_rd <= m1[s1_addr];
         if (s2_req && s2_we) begin
            for (int b = 0; b < 4; b++)
               if (s2_be[b]) m2[s2_addr[5:0]][8*b +: 8] <= s2_wd[8*b +: 8];
         end else if (s2_req) s2_rd <= m2[s2_addr[5:0]];
      end
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1);
   end

   task automatic push(int k, exp_t x);
      case (k)
         0: q0.push_back(x);
         1: q1.push_back(x);
         default: q2.push_back(x);
      endcase
   endtask

   task automatic mon(int k, logic e, logic [31:0] d);
      exp_t x;
      bit   have = 0;
      case (k)
         0: if (q0.size() != 0) begin x = q0.pop_front(); have = 1; end
         1: if (q1.size() != 0) begin x = q1.pop_front(); have = 1; end
         default:
            if (q2.size() != 0) begin x = q2.pop_front(); have = 1; end
      endcase
      checks++;
      if (!have) begin
         errors++;
         $display("FAIL resp%0d: unexpected rvalid err=%0b rdata=%h at cyc %0d, none required",
                  k, e, d, cyc);
      end else if (x.err !== e || x.rd !== d || x.cyc != cyc) begin
         errors++;
         $display("FAIL resp%0d: got err=%0b rdata=%h cyc=%0d, required err=%0b rdata=%h cyc=%0d",
                  k, e, d, cyc, x.err, x.rd, x.cyc);
      end
   endtask

   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (rv[k] === 1'b1) begin
            mon(k, eo[k], rd[k]);
         end else begin
            checks++;
            if (rv[k] !== 1'b0 || rd[k] !== 32'h0 || eo[k] !== 1'b0) begin
               errors++;
               $display("FAIL idle%0d: rvalid=%b err=%b rdata=%h, required 0/0/0",
                        k, rv[k], eo[k], rd[k]);
            end
         end
      end
   end

   // Called at a negedge; returns at the negedge after the grant cycle.
   task automatic issue(int k, bit w, logic [3:0] b, logic [31:0] a,
                        logic [31:0] wd, bit xerr, logic [31:0] xrd,
                        logic [31:0] xword);
      int   n = 0;
      bit   got = 0;
      exp_t x;
      req[k] = 1'b1;
      we[k] = w;
      be[k] = b;
      addr[k] = a;
      wdata[k] = wd;
      while (!got && n <= 20) begin
         #1;
         if (gnt[k]) begin
            got = 1;
            checks++;
            if (sreq[k] !== !xerr ||
                (!xerr && (saddr[k] !== xword || sbe[k] !== b))) begin
               errors++;
               $display("FAIL sram%0d @%h: req=%b addr=%h be=%b, required req=%b addr=%h be=%b",
                        k, a, sreq[k], saddr[k], sbe[k], !xerr, xword, b);
            end
            x.err = xerr;
            x.rd = xrd;
            x.cyc = cyc + LAT[k];
            push(k, x);
         end
         @(negedge clk);
         if (!got) n++;
      end
      req[k] = 1'b0;
      checks++;
      if (!got || n != GD[k]) begin
         errors++;
         $display("FAIL gnt_delay%0d @%h: got=%0b waited %0d, required %0d",
                  k, a, got, n, GD[k]);
      end
   endtask

   task automatic expect_no_gnt(int k, string tag);
      #1;
      checks++;
      if (gnt[k] !== 1'b0) begin
         errors++;
         $display("FAIL %s: gnt=%b, required 0", tag, gnt[k]);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         req[k] = 1'b0;
         we[k] = 1'b0;
         be[k] = 4'h0;
         addr[k] = 32'h0;
         wdata[k] = 32'h0;
      end
      repeat (3) @(negedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (gnt[k] !== 1'b0 || sreq[k] !== 1'b0 || rv[k] !== 1'b0) begin
            errors++;
            $display("FAIL reset%0d: gnt=%b sram_req=%b rvalid=%b, required 0",
                     k, gnt[k], sreq[k], rv[k]);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Configuration 0: GntDelay 0, RespLatency 1, base 0.
      issue(0, 0, 4'hF, 32'h10, 32'h0, 0, 32'hA500_0004, 32'h4);
      issue(0, 1, 4'b0011, 32'h20, 32'hDEAD_BEEF, 0, 32'h0, 32'h8);
      issue(0, 0, 4'hF, 32'h20, 32'h0, 0, 32'hA500_BEEF, 32'h8);
      issue(0, 0, 4'hF, 32'h0001_0000, 32'h0, 1, 32'h0, 32'h0);
      issue(0, 0, 4'hF, 32'h2, 32'h0, 1, 32'h0, 32'h0);
      issue(0, 1, 4'b0000, 32'h24, 32'hFFFF_FFFF, 0, 32'h0, 32'h9);
      issue(0, 0, 4'hF, 32'h24, 32'h0, 0, 32'hA500_0009, 32'h9);
      issue(0, 0, 4'hF, 32'hFFFC, 32'h0, 0, 32'hA500_003F, 32'h3FFF);
      repeat (3) @(negedge clk);

      // Configuration 1: GntDelay 3, base 0x1000, 256 bytes.
      req[1] = 1'b1;
      addr[1] = 32'h1010;
      we[1] = 1'b0;
      be[1] = 4'hF;
      expect_no_gnt(1, "drop_t0");
      @(negedge clk);
      expect_no_gnt(1, "drop_t1");
      @(negedge clk);
      req[1] = 1'b0;
      expect_no_gnt(1, "drop_t2");
      @(negedge clk);
      expect_no_gnt(1, "drop_t3");
      @(negedge clk);
      issue(1, 0, 4'hF, 32'h1010, 32'h0, 0, 32'hA500_0004, 32'h4);
      issue(1, 0, 4'hF, 32'h0FFC, 32'h0, 1, 32'h0, 32'h0);
      issue(1, 0, 4'hF, 32'h10FC, 32'h0, 0, 32'hA500_003F, 32'h3F);
      issue(1, 0, 4'hF, 32'h1100, 32'h0, 1, 32'h0, 32'h0);
      issue(1, 1, 4'hF, 32'h1001, 32'h1234_5678, 1, 32'h0, 32'h0);
      repeat (3) @(negedge clk);

      // Configuration 2: RespLatency 4, back-to-back reads.
      issue(2, 0, 4'hF, 32'h0, 32'h0, 0, 32'hA500_0000, 32'h0);
      issue(2, 0, 4'hF, 32'h4, 32'h0, 0, 32'hA500_0001, 32'h1);
      issue(2, 0, 4'hF, 32'h8, 32'h0, 0, 32'hA500_0002, 32'h2);
      issue(2, 0, 4'hF, 32'hC, 32'h0, 0, 32'hA500_0003, 32'h3);
      repeat (6) @(negedge clk);

      // Reset with two responses in flight: both must vanish.
      issue(2, 0, 4'hF, 32'h8, 32'h0, 0, 32'hA500_0002, 32'h2);
      issue(2, 0, 4'hF, 32'hC, 32'h0, 0, 32'hA500_0003, 32'h3);
      rst_n = 1'b0;
      q2.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      issue(2, 0, 4'hF, 32'h14, 32'h0, 0, 32'hA500_0005, 32'h5);
      repeat (6) @(negedge clk);

      checks++;
      if (q0.size() + q1.size() + q2.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d/%0d/%0d responses missing, required 0/0/0",
                  q0.size(), q1.size(), q2.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
